fifo_proc_reader: RTL and testbench

- Read-side bridge between the 16-bit sample FIFO and the processor's input port.
- Serves processor input requests (req_in strobes) by popping one FIFO word, sign-extending it to the processor data width, and presenting it with a one-cycle valid strobe.
- Also answers FIFO status queries.
- Provides timeout-based underflow handling so the processor never stalls indefinitely on an empty FIFO.

---
 rtl/fifo_proc_reader.sv | 171 +++++++++++++++++
 tb/tb_fifo_proc_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_proc_reader.sv
// fifo_proc_reader: read-side bridge between the signed sample FIFO and the
// processor input port.
//
// A data request (req_in[1]) pops one FIFO word and returns it sign-extended.
// A status request (req_in[0]) returns {fifo_empty, zeros, fifo_usedw}.
// Each answer is a one-cycle in_valid pulse. While the FIFO is empty, a data
// request waits up to TIMEOUT cycles. It then answers with zero and records
// an underflow.
//
// Ports:
//   clk, rst_geral   clock (rising edge); synchronous active-high reset
//   req_in[1:0]      bit1 = data read, bit0 = status read (one-cycle strobes)
//   fifo_q           FIFO read data (signed)
//   fifo_empty       FIFO empty flag
//   fifo_usedw       FIFO fill level
//   fifo_rdreq       FIFO pop request (one-cycle pulse)
//   proc_in          data to processor; holds between in_valid pulses
//   in_valid         proc_in valid strobe
//   busy             FSM outside IDLE
//   underflow        sticky: a data request timed out
//   req_err          sticky: request seen while busy
//   drop_cnt         timed-out data requests, saturating
module fifo_proc_reader #(
  parameter int DATA_W  = 16,
  parameter int USEDW_W = 7,
  parameter int PROC_W  = 32,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_geral,
  input  logic [1:0]         req_in,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  output logic [PROC_W-1:0]  proc_in,
  output logic               in_valid,
  output logic               busy,
  output logic               underflow,
  output logic               req_err,
  output logic [15:0]        drop_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  // timer_q counts the wait cycles that finished before the current edge.
  // The wait cycle that ends at this edge is therefore number timer_q+1.
  // The request times out when that number reaches TIMEOUT.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [1:0]       RD_LAST  = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_LATCH, S_STATUS
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         rd_cnt_q, rd_cnt_d;
  logic               pend_q, pend_d;       // status request held behind a data request
  logic               rdreq_q, rdreq_d;
  logic [PROC_W-1:0]  proc_q, proc_d;
  logic               vld_q, vld_d;
  logic               unf_q, unf_d;
  logic               err_q, err_d;
  logic [15:0]        drop_q, drop_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rd_cnt_d = rd_cnt_q;
    pend_d   = pend_q;
    rdreq_d  = 1'b0;
    proc_d   = proc_q;
    vld_d    = 1'b0;
    unf_d    = unf_q;
    err_d    = err_q;
    drop_d   = drop_q;

    // A request that arrives outside IDLE is dropped and flagged.
    if (state_q != S_IDLE && req_in != 2'b00) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_in[1]) begin
          pend_d = req_in[0];
          if (!fifo_empty) begin
            rdreq_d  = 1'b1;
            rd_cnt_d = '0;
            state_d  = S_READ;
          end else begin
            timer_d = '0;
            state_d = S_WAIT;
          end
        end else if (req_in[0]) begin
          state_d = S_STATUS;
        end
      end
      S_WAIT: begin
        // Check for data before the timeout, so data that arrives on the
        // last wait cycle is still read.
        if (!fifo_empty) begin
          rdreq_d  = 1'b1;
          rd_cnt_d = '0;
          state_d  = S_READ;
        end else if (timer_q == TMR_LAST) begin
          proc_d  = '0;
          vld_d   = 1'b1;
          unf_d   = 1'b1;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = pend_q ? S_STATUS : S_IDLE;
          pend_d  = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_READ: begin
        if (rd_cnt_q == RD_LAST) state_d = S_LATCH;
        else                     rd_cnt_d = rd_cnt_q + 2'd1;
      end
      S_LATCH: begin
        proc_d  = {{(PROC_W-DATA_W){fifo_q[DATA_W-1]}}, fifo_q};
        vld_d   = 1'b1;
        state_d = pend_q ? S_STATUS : S_IDLE;
        pend_d  = 1'b0;
      end
      S_STATUS: begin
        proc_d                 = '0;
        proc_d[PROC_W-1]       = fifo_empty;
        proc_d[USEDW_W-1:0]    = fifo_usedw;
        vld_d                  = 1'b1;
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_geral) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      rd_cnt_q <= '0;
      pend_q   <= 1'b0;
      rdreq_q  <= 1'b0;
      proc_q   <= '0;
      vld_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rd_cnt_q <= rd_cnt_d;
      pend_q   <= pend_d;
      rdreq_q  <= rdreq_d;
      proc_q   <= proc_d;
      vld_q    <= vld_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign fifo_rdreq = rdreq_q;
  assign proc_in    = proc_q;
  assign in_valid   = vld_q;
  assign busy       = (state_q != S_IDLE);
  assign underflow  = unf_q;
  assign req_err    = err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fifo_proc_reader.sv
// Directed bench for fifo_proc_reader (RD_LAT=1, TIMEOUT=15).
// The bench drives inputs 1 ns after a rising edge and samples at the same
// point, so each step shows the registered result of the edge just taken.
module tb_fifo_proc_reader;
  logic        clk = 1'b0;
  logic        rst_geral;
  logic [1:0]  req_in;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic [6:0]  fifo_usedw;
  logic        fifo_rdreq;
  logic [31:0] proc_in;
  logic        in_valid, busy, underflow, req_err;
  logic [15:0] drop_cnt;

  int nchk = 0, nerr = 0;
  int pops = 0, vcnt = 0;

  fifo_proc_reader #(.DATA_W(16), .USEDW_W(7), .PROC_W(32), .RD_LAT(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst_geral(rst_geral), .req_in(req_in), .fifo_q(fifo_q),
    .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw), .fifo_rdreq(fifo_rdreq),
    .proc_in(proc_in), .in_valid(in_valid), .busy(busy), .underflow(underflow),
    .req_err(req_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock edge. Afterwards, count the pops and valid pulses seen.
  task automatic step();
    @(posedge clk);
    #1;
    if (fifo_rdreq) pops++;
    if (in_valid)   vcnt++;
  endtask

  initial begin
    rst_geral = 1'b1; req_in = 2'b00; fifo_q = 16'h0000; fifo_empty = 1'b1; fifo_usedw = 7'd0;
    step(); step();
    chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    chk("rst_valid", {31'd0, in_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_proc",  proc_in, 32'd0);
    chk("rst_unf",   {31'd0, underflow}, 32'd0);
    chk("rst_err",   {31'd0, req_err}, 32'd0);
    chk("rst_drop",  {16'd0, drop_cnt}, 32'd0);
    rst_geral = 1'b0;
    step();

    // Data read of a negative sample from a non-empty FIFO
    fifo_empty = 1'b0; fifo_q = 16'hD45C; fifo_usedw = 7'd5; pops = 0; vcnt = 0;
    req_in = 2'b10; step(); req_in = 2'b00;
    chk("t1_rdreq", {31'd0, fifo_rdreq}, 32'd1);
    chk("t1_busy",  {31'd0, busy}, 32'd1);
    step();
    chk("t1_rdreq_off", {31'd0, fifo_rdreq}, 32'd0);
    chk("t1_noval", {31'd0, in_valid}, 32'd0);
    step();
    chk("t1_valid", {31'd0, in_valid}, 32'd1);
    chk("t1_proc",  proc_in, 32'hFFFFD45C);
    chk("t1_busy0", {31'd0, busy}, 32'd0);
    step();
    chk("t1_val_off", {31'd0, in_valid}, 32'd0);
    chk("t1_hold",  proc_in, 32'hFFFFD45C);
    chk("t1_pops",  pops, 32'd1);

    // The FIFO is empty when the request arrives and fills 10 cycles later
    fifo_empty = 1'b1; fifo_q = 16'd100; pops = 0;
    req_in = 2'b10; step(); req_in = 2'b00;
    chk("t2_busy", {31'd0, busy}, 32'd1);
    repeat (9) step();
    chk("t2_no_pop", pops, 32'd0);
    fifo_empty = 1'b0;
    step();
    chk("t2_rdreq", {31'd0, fifo_rdreq}, 32'd1);
    fifo_empty = 1'b1;
    step();
    step();
    chk("t2_valid", {31'd0, in_valid}, 32'd1);
    chk("t2_proc",  proc_in, 32'd100);
    chk("t2_unf",   {31'd0, underflow}, 32'd0);
    chk("t2_pops",  pops, 32'd1);

    // Timeout: the FIFO stays empty for TIMEOUT+5 cycles
    pops = 0; vcnt = 0;
    req_in = 2'b10; step(); req_in = 2'b00;
    repeat (14) step();
    chk("t3_early", vcnt, 32'd0);
    step();
    chk("t3_valid", {31'd0, in_valid}, 32'd1);
    chk("t3_proc",  proc_in, 32'd0);
    chk("t3_unf",   {31'd0, underflow}, 32'd1);
    chk("t3_drop",  {16'd0, drop_cnt}, 32'd1);
    chk("t3_busy0", {31'd0, busy}, 32'd0);
    repeat (4) step();
    chk("t3_vcnt",  vcnt, 32'd1);
    chk("t3_pops",  pops, 32'd0);

    // Data and status requested together
    fifo_empty = 1'b0; fifo_q = 16'h1234; fifo_usedw = 7'd37; pops = 0; vcnt = 0;
    req_in = 2'b11; step(); req_in = 2'b00;
    step(); step();
    chk("t4_v1",    {31'd0, in_valid}, 32'd1);
    chk("t4_data",  proc_in, 32'h00001234);
    step();
    chk("t4_v2",    {31'd0, in_valid}, 32'd1);
    chk("t4_stat",  proc_in, 32'd37);
    step();
    chk("t4_voff",  {31'd0, in_valid}, 32'd0);
    chk("t4_pops",  pops, 32'd1);
    chk("t4_noerr", {31'd0, req_err}, 32'd0);

    // A status request that arrives during READ
    vcnt = 0;
    req_in = 2'b10; step(); req_in = 2'b01; step(); req_in = 2'b00;
    chk("t5_err",   {31'd0, req_err}, 32'd1);
    step();
    chk("t5_data",  proc_in, 32'h00001234);
    repeat (3) step();
    chk("t5_vcnt",  vcnt, 32'd1);
    chk("t5_idle",  {31'd0, busy}, 32'd0);

    // Reset asserted one cycle after rdreq
    fifo_q = 16'h8001; vcnt = 0;
    req_in = 2'b10; step(); req_in = 2'b00;
    chk("t6_rdreq", {31'd0, fifo_rdreq}, 32'd1);
    rst_geral = 1'b1; step(); rst_geral = 1'b0;
    chk("t6_rdreq0", {31'd0, fifo_rdreq}, 32'd0);
    chk("t6_busy0",  {31'd0, busy}, 32'd0);
    chk("t6_proc0",  proc_in, 32'd0);
    chk("t6_err0",   {31'd0, req_err}, 32'd0);
    chk("t6_unf0",   {31'd0, underflow}, 32'd0);
    chk("t6_drop0",  {16'd0, drop_cnt}, 32'd0);
    repeat (3) step();
    chk("t6_noval",  vcnt, 32'd0);
    req_in = 2'b10; step(); req_in = 2'b00;
    step(); step();
    chk("t6_valid",  {31'd0, in_valid}, 32'd1);
    chk("t6_proc",   proc_in, 32'hFFFF8001);
    step();

    // Status request alone, with the FIFO empty
    fifo_empty = 1'b1; fifo_usedw = 7'd3;
    req_in = 2'b01; step(); req_in = 2'b00;
    chk("t7_busy",   {31'd0, busy}, 32'd1);
    step();
    chk("t7_valid",  {31'd0, in_valid}, 32'd1);
    chk("t7_stat",   proc_in, 32'h80000003);
    step();
    chk("t7_voff",   {31'd0, in_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
